// File: rtl/z80_reti_dec.sv
// z80_reti_dec
// Watches Z80 bus cycles and generates the daisy-chain strobes that Z80-family
// peripherals (CTC, PIO, SIO) expect. It tracks opcode prefixes so that only a
// genuine ED 4D (RETI) or ED 45 (RETN) produces a pulse. It also keeps an
// interrupt nesting depth that rises on each acknowledge and falls on each RETI.
//
// Ports
//   I_CLK       system clock
//   I_RESET_n   asynchronous active-low reset
//   I_CLKEN     CPU clock enable; every sample and every state update is gated by it
//   I_M1_n, I_MREQ_n, I_IORQ_n, I_RD_n   CPU bus strobes (active low)
//   I_D         CPU data-in bus (opcode byte during a fetch)
//   O_SPM1      registered interrupt-acknowledge (special M1)
//   O_RETI      one-CLKEN-period pulse after an ED 4D commits
//   O_RETN      one-CLKEN-period pulse after an ED 45 commits
//   O_PFX       prefix state: 0=IDLE 1=CB 2=DDFD 3=ED
//   O_DEPTH     interrupt nesting depth (saturating)
module z80_reti_dec #(
  parameter int DEPTH_W = 4
) (
  input  logic               I_CLK,
  input  logic               I_RESET_n,
  input  logic               I_CLKEN,
  input  logic               I_M1_n,
  input  logic               I_MREQ_n,
  input  logic               I_IORQ_n,
  input  logic               I_RD_n,
  input  logic [7:0]         I_D,
  output logic               O_SPM1,
  output logic               O_RETI,
  output logic               O_RETN,
  output logic [1:0]         O_PFX,
  output logic [DEPTH_W-1:0] O_DEPTH
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CB   = 2'd1,
    S_DDFD = 2'd2,
    S_ED   = 2'd3
  } pfx_t;

  localparam logic [7:0] OP_CB = 8'hCB;
  localparam logic [7:0] OP_DD = 8'hDD;
  localparam logic [7:0] OP_ED = 8'hED;
  localparam logic [7:0] OP_FD = 8'hFD;
  localparam logic [7:0] OP_RETI = 8'h4D;
  localparam logic [7:0] OP_RETN = 8'h45;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  pfx_t               state, state_nxt;
  logic [7:0]         op_r;
  logic               fetch_r;
  logic [DEPTH_W-1:0] depth_nxt;

  logic fetch, intack, commit, reti_hit, retn_hit, depth_inc, depth_dec;

  // Bus cycle classification (only meaningful on CLKEN cycles).
  assign fetch  = ~I_M1_n & ~I_MREQ_n & ~I_RD_n;
  assign intack = ~I_M1_n & ~I_IORQ_n;

  // The opcode is acted on once M1 has gone away; the byte seen last during
  // the fetch is the one that counts.
  assign commit = I_M1_n & fetch_r;

  assign reti_hit = commit && (state == S_ED) && (op_r == OP_RETI);
  assign retn_hit = commit && (state == S_ED) && (op_r == OP_RETN);

  // Depth counts the 0->1 edge of the registered acknowledge, i.e. it moves in
  // the same CLKEN cycle that O_SPM1 rises.
  assign depth_inc = intack & ~O_SPM1;
  assign depth_dec = reti_hit;

  always_comb begin
    state_nxt = state;
    if (commit) begin
      unique case (state)
        S_IDLE: begin
          if (op_r == OP_CB)                        state_nxt = S_CB;
          else if (op_r == OP_ED)                   state_nxt = S_ED;
          else if (op_r == OP_DD || op_r == OP_FD)  state_nxt = S_DDFD;
          else                                      state_nxt = S_IDLE;
        end
        // Second byte of a CB opcode: never a prefix, so CB ED stays out of ED.
        S_CB: state_nxt = S_IDLE;
        S_DDFD: begin
          // DD CB d op: displacement and final byte are not M1 fetches.
          if (op_r == OP_ED)                        state_nxt = S_ED;
          else if (op_r == OP_DD || op_r == OP_FD)  state_nxt = S_DDFD;
          else                                      state_nxt = S_IDLE;
        end
        S_ED:    state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    depth_nxt = O_DEPTH;
    if (depth_inc && !depth_dec && O_DEPTH != DEPTH_MAX)
      depth_nxt = O_DEPTH + DEPTH_ONE;
    else if (depth_dec && !depth_inc && O_DEPTH != '0)
      depth_nxt = O_DEPTH - DEPTH_ONE;
  end

  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state   <= S_IDLE;
      op_r    <= 8'h00;
      fetch_r <= 1'b0;
      O_SPM1  <= 1'b0;
      O_RETI  <= 1'b0;
      O_RETN  <= 1'b0;
      O_DEPTH <= '0;
    end else if (I_CLKEN) begin
      state <= state_nxt;
      // fetch needs M1 low and commit needs M1 high, so they never coincide.
      if (fetch) begin
        op_r    <= I_D;
        fetch_r <= 1'b1;
      end else if (commit) begin
        fetch_r <= 1'b0;
      end
      O_SPM1  <= intack;
      O_RETI  <= reti_hit;
      O_RETN  <= retn_hit;
      O_DEPTH <= depth_nxt;
    end
  end

  assign O_PFX = state;

endmodule

// File: tb/tb_z80_reti_dec.sv
module tb_z80_reti_dec;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clken;
  logic          m1_n, mreq_n, iorq_n, rd_n;
  logic [7:0]    d;
  logic          spm1, reti, retn;
  logic [1:0]    pfx;
  logic [DW-1:0] depth;

  z80_reti_dec #(.DEPTH_W(DW)) dut (
    .I_CLK(clk), .I_RESET_n(rst_n), .I_CLKEN(clken),
    .I_M1_n(m1_n), .I_MREQ_n(mreq_n), .I_IORQ_n(iorq_n), .I_RD_n(rd_n),
    .I_D(d),
    .O_SPM1(spm1), .O_RETI(reti), .O_RETN(retn), .O_PFX(pfx), .O_DEPTH(depth)
  );

  always #5 clk = ~clk;

  int cmp_n = 0;
  int err_n = 0;
  bit done = 0;
  int div = 1;

  // ---------------- reference model ----------------
  // Prefix state as a number: 0 idle, 1 after CB, 2 after DD/FD, 3 after ED.
  int   m_pfx;
  logic [7:0] m_op;
  bit   m_pending;
  bit   m_spm1, m_reti, m_retn;
  int   m_depth;

  function automatic int next_pfx(input int s, input logic [7:0] b);
    if (s == 0) begin
      if (b == 8'hCB) return 1;
      if (b == 8'hED) return 3;
      if (b == 8'hDD || b == 8'hFD) return 2;
      return 0;
    end
    if (s == 2) begin
      if (b == 8'hED) return 3;
      if (b == 8'hDD || b == 8'hFD) return 2;
      return 0;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit is_fetch, is_ack, do_commit, got_reti, got_retn, ack_rise;
    int nd;
    if (!rst_n) begin
      m_pfx <= 0; m_op <= 8'h00; m_pending <= 0;
      m_spm1 <= 0; m_reti <= 0; m_retn <= 0; m_depth <= 0;
    end else if (clken) begin
      is_fetch  = !m1_n && !mreq_n && !rd_n;
      is_ack    = !m1_n && !iorq_n;
      do_commit = m1_n && m_pending;
      got_reti  = do_commit && m_pfx == 3 && m_op == 8'h4D;
      got_retn  = do_commit && m_pfx == 3 && m_op == 8'h45;
      ack_rise  = is_ack && !m_spm1;
      nd = m_depth + (ack_rise ? 1 : 0) - (got_reti ? 1 : 0);
      if (nd < 0) nd = 0;
      if (nd > (1 << DW) - 1) nd = (1 << DW) - 1;
      if (do_commit) begin
        m_pfx <= next_pfx(m_pfx, m_op);
        m_pending <= 0;
      end
      if (is_fetch) begin
        m_op <= d;
        m_pending <= 1;
      end
      m_spm1  <= is_ack;
      m_reti  <= got_reti;
      m_retn  <= got_retn;
      m_depth <= nd;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!done) begin
      cmp_n++;
      if (spm1 !== m_spm1 || reti !== m_reti || retn !== m_retn ||
          int'(pfx) != m_pfx || int'(depth) != m_depth || $isunknown({spm1, reti, retn, pfx, depth})) begin
        err_n++;
        $display("FAIL cycle t=%0t got spm1=%b reti=%b retn=%b pfx=%0d depth=%0d exp spm1=%b reti=%b retn=%b pfx=%0d depth=%0d",
                 $time, spm1, reti, retn, pfx, depth, m_spm1, m_reti, m_retn, m_pfx, m_depth);
      end
    end
  end

  // Event monitors for the hand-computed checks.
  int reti_pulses = 0, retn_pulses = 0, reti_hi = 0, spm1_hi = 0;
  logic reti_q = 0, retn_q = 0;
  always @(negedge clk) begin
    if (reti && !reti_q) reti_pulses++;
    if (retn && !retn_q) retn_pulses++;
    if (reti) reti_hi++;
    if (spm1) spm1_hi++;
    reti_q <= reti;
    retn_q <= retn;
  end

  task automatic chk(input string name, input int got, input int exp);
    cmp_n++;
    if (got != exp) begin
      err_n++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic bus(input logic a_m1, input logic a_mreq, input logic a_iorq,
                     input logic a_rd, input logic [7:0] a_d);
    m1_n = a_m1; mreq_n = a_mreq; iorq_n = a_iorq; rd_n = a_rd; d = a_d;
  endtask

  // One CPU clock: `div` system clocks, CLKEN on the last of them.
  task automatic tick();
    for (int i = 0; i < div; i++) begin
      clken = (i == div - 1);
      @(negedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    bus(1, 1, 1, 1, 8'hFF);
    repeat (n) tick();
  endtask

  // Two-cycle M1 fetch followed by the cycle in which it commits.
  task automatic fetch(input logic [7:0] b);
    bus(0, 0, 1, 0, b);
    tick(); tick();
    idle(1);
  endtask

  task automatic memrd(input logic [7:0] b);
    bus(1, 0, 1, 0, b);
    tick(); tick();
    idle(1);
  endtask

  task automatic ack(input int n);
    bus(0, 1, 0, 1, 8'hFF);
    repeat (n) tick();
    idle(1);
  endtask

  int p0, h0;

  initial begin
    rst_n = 0; clken = 1;
    bus(1, 1, 1, 1, 8'hFF);
    @(negedge clk); #1;
    chk("reset_outs", int'({spm1, reti, retn, pfx, depth}), 0);
    @(negedge clk); #1;
    rst_n = 1;
    idle(2);

    // ED 4D: PFX 3 then 0, RETI one cycle after commit, no RETN.
    p0 = reti_pulses;
    fetch(8'hED);
    chk("ed_pfx", pfx, 3);
    fetch(8'h4D);
    chk("reti_hi_after_commit", reti, 1);
    chk("pfx_after_4d", pfx, 0);
    idle(1);
    chk("reti_cleared", reti, 0);
    chk("reti_once", reti_pulses - p0, 1);
    chk("no_retn", retn_pulses, 0);

    // CB ED 4D: the ED is the CB's second byte.
    p0 = reti_pulses;
    fetch(8'hCB); chk("cb_pfx", pfx, 1);
    fetch(8'hED); chk("cb_ed_pfx", pfx, 0);
    fetch(8'h4D); chk("cb_ed_4d_pfx", pfx, 0);
    idle(1);
    chk("cb_ed_4d_no_reti", reti_pulses - p0, 0);

    // DD ED 4D still a RETI.
    p0 = reti_pulses;
    fetch(8'hDD); chk("dd_pfx", pfx, 2);
    fetch(8'hED); fetch(8'h4D);
    idle(1);
    chk("dd_ed_4d_reti", reti_pulses - p0, 1);

    // DD CB d op: trailing bytes are plain reads.
    p0 = reti_pulses;
    fetch(8'hDD); fetch(8'hCB);
    chk("dd_cb_pfx", pfx, 0);
    memrd(8'hED); memrd(8'h4D);
    fetch(8'h4D);
    idle(1);
    chk("dd_cb_no_reti", reti_pulses - p0, 0);

    // Nesting depth: two acknowledges, RETI, RETN, RETI, RETI.
    h0 = spm1_hi;
    ack(3);
    chk("spm1_3cycles", spm1_hi - h0, 3);
    chk("depth_1", depth, 1);
    idle(1);
    ack(3);
    chk("depth_2", depth, 2);
    fetch(8'hED); fetch(8'h4D); idle(1);
    chk("depth_after_reti1", depth, 1);
    p0 = retn_pulses;
    fetch(8'hED); fetch(8'h45);
    chk("retn_hi", retn, 1);
    chk("reti_lo_on_retn", reti, 0);
    idle(1);
    chk("retn_once", retn_pulses - p0, 1);
    chk("depth_retn_same", depth, 1);
    fetch(8'hED); fetch(8'h4D); idle(1);
    chk("depth_0", depth, 0);
    fetch(8'hED); fetch(8'h4D); idle(1);
    chk("depth_floor", depth, 0);

    // CLKEN one in four: pulse spans four system clocks.
    div = 4;
    fetch(8'hED);
    h0 = reti_hi;
    fetch(8'h4D);
    idle(1);
    chk("reti_4clk", reti_hi - h0, 4);
    chk("pfx_div4", pfx, 0);
    div = 1;

    // Depth saturates at the top.
    for (int i = 0; i < 17; i++) ack(1);
    chk("depth_sat", depth, 15);
    fetch(8'hED); fetch(8'h4D); idle(1);
    chk("depth_sat_dec", depth, 14);

    // Reset between ED and 4D discards the prefix.
    p0 = reti_pulses;
    fetch(8'hED);
    rst_n = 0; #1;
    chk("rst_mid_outs", int'({spm1, reti, retn, pfx, depth}), 0);
    idle(1);
    rst_n = 1;
    fetch(8'h4D); idle(1);
    chk("rst_no_reti", reti_pulses - p0, 0);

    // Reset during a RETI pulse kills it at once.
    fetch(8'hED); fetch(8'h4D);
    chk("pulse_before_rst", reti, 1);
    rst_n = 0; #1;
    chk("pulse_killed", reti, 0);
    idle(1);
    rst_n = 1;
    idle(2);

    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
